fb_read_arbiter: RTL and testbench
==================================

# fb_read_arbiter

Arbitrates the single synchronous read port of the current framebuffer between the driver, which streams channel data out to the LED boards, and the animator, which reads current values to interpolate toward the target frame. It issues at most one read per cycle, routes each returned word to the requester that issued it, and gives the driver priority. A bounded starvation guard guarantees the animator forward progress. It sits between the driver/animator read interfaces and the framebuffer `i_raddr`/`o_rdata` pair.

## Interface
- `c_ledboards`, default 30: LED boards in the chain. There are `c_ledboards*32` channels, and `c_addr_w = $clog2(c_ledboards*32)`.
- `c_bpc`, default 12: bits per channel.
- `c_starve_limit`, default 8: consecutive denied animator cycles before the animator is forced through. Must be ≥1.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  asynchronous active-high reset
- `i_drv_req`  in  1  driver read request
- `i_drv_addr`  in  c_addr_w  driver read address
- `o_drv_gnt`  out  1  driver request accepted this cycle (combinational)
- `o_drv_valid`  out  1  `o_drv_data` valid, one-cycle pulse per accepted read
- `o_drv_data`  out  c_bpc  driver read data
- `i_ani_req`  in  1  animator read request
- `i_ani_addr`  in  c_addr_w  animator read address
- `o_ani_gnt`  out  1  animator request accepted this cycle (combinational)
- `o_ani_valid`  out  1  `o_ani_data` valid, one-cycle pulse
- `o_ani_data`  out  c_bpc  animator read data
- `o_fb_raddr`  out  c_addr_w  framebuffer read address (registered)
- `i_fb_rdata`  in  c_bpc  framebuffer read data, valid one cycle after `o_fb_raddr` is presented

## Operation
- **Handshake:** a transfer occurs on a rising edge where `req && gnt`. The requester holds req and addr stable until the transfer. Keeping req high after a transfer is a new request with the currently presented address; this allows streaming at one read per cycle. `gnt` depends only on `req` inputs and registered state, never on addr.
- **Arbitration:**
  - Normally the driver wins.
  - When `starve_cnt == c_starve_limit` and `i_ani_req=1`, the animator wins and `o_drv_gnt=0` that cycle.
  - If only one requester is active, it is granted.
  - At most one gnt is high per cycle.
- **Starvation counter:** width `$clog2(c_starve_limit+1)`.
  - Increments when `i_ani_req=1` and `o_ani_gnt=0`.
  - Clears on any animator transfer, or when `i_ani_req=0`.
  - Saturates at `c_starve_limit`.
- **Issue:**
  - On transfer, `o_fb_raddr <=` the winning address, and a 1-bit tag (driver/animator) plus an in-flight valid bit enter a 2-stage pipeline.
  - With no transfer, `o_fb_raddr` holds its value and a bubble enters the pipeline.
- **Return:** at pipeline stage 2, `i_fb_rdata` is registered into the tagged requester's data output and that requester's valid is pulsed. The other requester's data register holds its old value and its valid stays 0.
- **Ordering:** returns are in issue order per requester. There is no reordering and no buffering; requesters must always accept valid (no backpressure on the return path).
- **Address range:** addresses ≥ `c_ledboards*32` are forwarded unmodified; no check is made.

## Timing
- **Transfer to return:** a transfer in cycle N gives `o_fb_raddr` = addr in cycle N+1, and the requester's valid=1 with data in cycle N+3, for exactly one cycle.
- **Throughput:** 1 read/cycle aggregate. Up to 3 reads are in flight.
- **Both requesting continuously:** the driver receives `c_starve_limit` grants, then the animator receives 1. The period is `c_starve_limit+1` cycles.
- **Reset values:** all registered outputs are 0, `starve_cnt`=0, pipeline valid bits are 0. While `i_rst`=1, both gnt outputs are forced to 0.
- **Reset mid-operation:** in-flight reads are discarded, and no valid pulse appears in any cycle after reset assertion until new transfers complete.
- **Reset release:** the first cycle after release is arbitrated normally.

## Test plan
- **Reset:** assert `i_rst` with both req=1 and addresses 7/9 -> both gnt=0; `o_fb_raddr`, valids and data are 0 throughout and stay 0 for 3 cycles after release if reqs are low.
- **Single driver read:** driver req addr 5 in cycle 10 only, framebuffer model returns 0xA05 -> `o_drv_gnt`=1 in cycle 10, `o_fb_raddr`=5 in cycle 11, `o_drv_valid`=1 with 0xA05 in cycle 13 only, `o_ani_valid` never pulses.
- **Continuous contention:** both req continuously, `c_starve_limit`=8, driver addrs 0,1,2… and animator addr 100,101… -> driver granted cycles 0-7, animator cycle 8, repeating. Every return reaches the correct requester with the model value for its address.
- **Animator streaming:** animator alone, addresses 0..959 back-to-back -> gnt high every cycle, 960 consecutive `o_ani_valid` pulses in order with matching data, `starve_cnt` stays 0.
- **Reset with reads in flight:** transfers in cycles 20 and 21, reset asserted in cycle 22 -> no valid pulse from cycle 22 onward, and `starve_cnt`=0 after release.
- **Intermittent animator:** animator req high 3 cycles, low 1, repeated, while driver requests continuously with `c_starve_limit`=8 -> counter clears on each gap, and the animator is never granted.

Source files
------------

// File: rtl/fb_read_arbiter_if.sv
// Read-port bundle shared by the driver, the animator and the framebuffer.
// The slave side is the arbiter; the master side is whatever drives requests
// and models the framebuffer.
interface fb_read_arbiter_if #(
  parameter int unsigned c_addr_w = 10,
  parameter int unsigned c_bpc    = 12
);
  logic                i_drv_req;
  logic [c_addr_w-1:0] i_drv_addr;
  logic                o_drv_gnt;
  logic                o_drv_valid;
  logic [c_bpc-1:0]    o_drv_data;

  logic                i_ani_req;
  logic [c_addr_w-1:0] i_ani_addr;
  logic                o_ani_gnt;
  logic                o_ani_valid;
  logic [c_bpc-1:0]    o_ani_data;

  logic [c_addr_w-1:0] o_fb_raddr;
  logic [c_bpc-1:0]    i_fb_rdata;

  modport slave (
    input  i_drv_req, i_drv_addr, i_ani_req, i_ani_addr, i_fb_rdata,
    output o_drv_gnt, o_drv_valid, o_drv_data,
    output o_ani_gnt, o_ani_valid, o_ani_data, o_fb_raddr
  );

  modport master (
    output i_drv_req, i_drv_addr, i_ani_req, i_ani_addr, i_fb_rdata,
    input  o_drv_gnt, o_drv_valid, o_drv_data,
    input  o_ani_gnt, o_ani_valid, o_ani_data, o_fb_raddr
  );
endinterface

// File: rtl/fb_read_arbiter.sv
// Shares the framebuffer's single synchronous read port between the LED driver
// (priority) and the animator, with a starvation guard that forces the animator
// through after c_starve_limit consecutive denials. Returned words are steered
// back to the issuing requester three cycles after the transfer.
module fb_read_arbiter #(
  parameter int unsigned c_ledboards    = 30,
  parameter int unsigned c_bpc          = 12,
  parameter int unsigned c_starve_limit = 8
) (
  input logic              i_clk,
  input logic              i_rst,
  fb_read_arbiter_if.slave bus
);
  localparam int unsigned c_addr_w = $clog2(c_ledboards * 32);
  localparam int unsigned c_cnt_w  = $clog2(c_starve_limit + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_starve_limit);

  logic [c_cnt_w-1:0]  starve_cnt_q, starve_cnt_d;
  logic [c_addr_w-1:0] fb_raddr_q, fb_raddr_d;
  // Pipeline tag: 1 = animator, 0 = driver.
  logic                s1_valid_q, s1_valid_d, s1_tag_q, s1_tag_d;
  logic                s2_valid_q, s2_valid_d, s2_tag_q, s2_tag_d;
  logic                drv_valid_q, drv_valid_d, ani_valid_q, ani_valid_d;
  logic [c_bpc-1:0]    drv_data_q, drv_data_d, ani_data_q, ani_data_d;

  logic ani_force, drv_gnt, ani_gnt;

  // Grant decision: driver first unless the animator has waited long enough.
  always_comb begin
    ani_force = bus.i_ani_req && (starve_cnt_q == c_cnt_max);
    drv_gnt   = !i_rst && bus.i_drv_req && !ani_force;
    ani_gnt   = !i_rst && bus.i_ani_req && (ani_force || !bus.i_drv_req);
  end

  // Starvation counter, saturating; cleared when the animator is idle or served.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.i_ani_req || ani_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != c_cnt_max) begin
      starve_cnt_d = starve_cnt_q + c_cnt_w'(1);
    end
  end

  // Issue the winning address and push a tagged slot (or a bubble) into the pipe.
  always_comb begin
    fb_raddr_d = fb_raddr_q;
    if (drv_gnt) begin
      fb_raddr_d = bus.i_drv_addr;
    end else if (ani_gnt) begin
      fb_raddr_d = bus.i_ani_addr;
    end
    s1_valid_d = drv_gnt || ani_gnt;
    s1_tag_d   = ani_gnt;
    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
  end

  // Return: framebuffer data lines up with stage 2; capture it for the tagged owner.
  always_comb begin
    drv_valid_d = s2_valid_q && !s2_tag_q;
    ani_valid_d = s2_valid_q && s2_tag_q;
    drv_data_d  = drv_valid_d ? bus.i_fb_rdata : drv_data_q;
    ani_data_d  = ani_valid_d ? bus.i_fb_rdata : ani_data_q;
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt_q <= '0;
      fb_raddr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_tag_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_tag_q     <= 1'b0;
      drv_valid_q  <= 1'b0;
      ani_valid_q  <= 1'b0;
      drv_data_q   <= '0;
      ani_data_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      fb_raddr_q   <= fb_raddr_d;
      s1_valid_q   <= s1_valid_d;
      s1_tag_q     <= s1_tag_d;
      s2_valid_q   <= s2_valid_d;
      s2_tag_q     <= s2_tag_d;
      drv_valid_q  <= drv_valid_d;
      ani_valid_q  <= ani_valid_d;
      drv_data_q   <= drv_data_d;
      ani_data_q   <= ani_data_d;
    end
  end

  assign bus.o_drv_gnt   = drv_gnt;
  assign bus.o_ani_gnt   = ani_gnt;
  assign bus.o_fb_raddr  = fb_raddr_q;
  assign bus.o_drv_valid = drv_valid_q;
  assign bus.o_drv_data  = drv_data_q;
  assign bus.o_ani_valid = ani_valid_q;
  assign bus.o_ani_data  = ani_data_q;
endmodule

// File: tb/tb_fb_read_arbiter.sv
// Directed bench for fb_read_arbiter with default parameters (30 boards, 12 bpc,
// starvation limit 8). Framebuffer content is addr ^ 0xA00.
module tb_fb_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  fb_read_arbiter_if #(.c_addr_w(10), .c_bpc(12)) bus ();

  fb_read_arbiter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] fbv(input logic [9:0] a);
    return 12'hA00 ^ {2'b00, a};
  endfunction

  // Synchronous-read framebuffer.
  always @(posedge clk) bus.i_fb_rdata <= fbv(bus.o_fb_raddr);

  int passes = 0;
  int total  = 0;
  int ani_pulses = 0;

  // Expected register state, advanced from the hand-specified grants.
  logic [9:0]  m_raddr;
  logic        m_s1v, m_s1t, m_s2v, m_s2t;
  logic [9:0]  m_s1a, m_s2a;
  logic        m_dv, m_av;
  logic [11:0] m_dd, m_ad;
  logic        pend_v, pend_t;
  logic [9:0]  pend_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    m_raddr = '0; m_s1v = 0; m_s1t = 0; m_s2v = 0; m_s2t = 0;
    m_s1a = '0; m_s2a = '0; m_dv = 0; m_av = 0; m_dd = '0; m_ad = '0;
    pend_v = 0; pend_t = 0; pend_a = '0;
  endtask

  // One clock cycle: advance the model, drive inputs, check at the falling edge.
  task automatic tick(input logic r, input logic dr, input logic [9:0] da,
                      input logic ar, input logic [9:0] aa,
                      input logic edg, input logic eag, input string tag);
    @(posedge clk);
    m_dv = m_s2v && !m_s2t;
    m_av = m_s2v && m_s2t;
    if (m_dv) m_dd = fbv(m_s2a);
    if (m_av) m_ad = fbv(m_s2a);
    m_s2v = m_s1v; m_s2t = m_s1t; m_s2a = m_s1a;
    m_s1v = pend_v; m_s1t = pend_t; m_s1a = pend_a;
    if (pend_v) m_raddr = pend_a;
    #1;
    rst = r;
    bus.i_drv_req = dr; bus.i_drv_addr = da;
    bus.i_ani_req = ar; bus.i_ani_addr = aa;
    if (r) model_clear();
    pend_v = edg || eag;
    pend_t = eag;
    pend_a = eag ? aa : da;
    @(negedge clk);
    chk({tag, ".drv_gnt"}, 32'(bus.o_drv_gnt), 32'(edg));
    chk({tag, ".ani_gnt"}, 32'(bus.o_ani_gnt), 32'(eag));
    chk({tag, ".raddr"}, 32'(bus.o_fb_raddr), 32'(m_raddr));
    chk({tag, ".drv_valid"}, 32'(bus.o_drv_valid), 32'(m_dv));
    chk({tag, ".drv_data"}, 32'(bus.o_drv_data), 32'(m_dd));
    chk({tag, ".ani_valid"}, 32'(bus.o_ani_valid), 32'(m_av));
    chk({tag, ".ani_data"}, 32'(bus.o_ani_data), 32'(m_ad));
    if (bus.o_ani_valid === 1'b1) ani_pulses++;
  endtask

  initial begin
    int da;
    int aa;
    model_clear();
    bus.i_drv_req = 0; bus.i_drv_addr = '0;
    bus.i_ani_req = 0; bus.i_ani_addr = '0;

    // Reset held with both requesting: no grants, all outputs zero.
    for (int i = 0; i < 3; i++) tick(1, 1, 10'd7, 1, 10'd9, 0, 0, "reset");
    chk("reset.starve", 32'(dut.starve_cnt_q), 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "post_reset");

    // Single driver read of address 5.
    tick(0, 1, 10'd5, 0, 10'd0, 1, 0, "single");
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "single");
    chk("single.raddr5", 32'(bus.o_fb_raddr), 32'd5);
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "single");
    chk("single.no_early_valid", 32'(bus.o_drv_valid), 0);
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "single");
    chk("single.valid", 32'(bus.o_drv_valid), 1);
    chk("single.data", 32'(bus.o_drv_data), 32'h0A05);
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "single");
    chk("single.one_pulse", 32'(bus.o_drv_valid), 0);
    chk("single.ani_quiet", 32'(bus.o_ani_valid), 0);

    // Continuous contention: eight driver grants then one animator grant.
    da = 0; aa = 100;
    for (int i = 0; i < 36; i++) begin
      logic ani_turn;
      ani_turn = (i % 9) == 8;
      tick(0, 1, 10'(da), 1, 10'(aa), !ani_turn, ani_turn, "contend");
      chk("contend.starve", 32'(dut.starve_cnt_q), 32'(i % 9));
      if (ani_turn) aa++;
      else da++;
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "contend_drain");

    // Animator streaming over the whole address range.
    ani_pulses = 0;
    for (int i = 0; i < 960; i++) begin
      tick(0, 0, 10'd0, 1, 10'(i), 0, 1, "stream");
      if (i % 97 == 0) chk("stream.starve", 32'(dut.starve_cnt_q), 0);
    end
    for (int i = 0; i < 4; i++) tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "stream_drain");
    chk("stream.pulse_count", 32'(ani_pulses), 32'd960);

    // Intermittent animator: gaps clear the counter before it reaches the limit.
    for (int i = 0; i < 16; i++) begin
      tick(0, 1, 10'(i), (i % 4) != 3, 10'd200, 1, 0, "intermit");
      chk("intermit.starve", 32'(dut.starve_cnt_q), 32'(i % 4));
    end
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "intermit_end");
    chk("intermit.cleared", 32'(dut.starve_cnt_q), 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "intermit_drain");

    // Reset with two reads in flight and a partially starved animator.
    tick(0, 1, 10'd3, 1, 10'd50, 1, 0, "flight");
    tick(0, 1, 10'd4, 1, 10'd50, 1, 0, "flight");
    chk("flight.starve_pre", 32'(dut.starve_cnt_q), 1);
    tick(1, 1, 10'd4, 1, 10'd50, 0, 0, "flight_rst");
    tick(1, 1, 10'd4, 1, 10'd50, 0, 0, "flight_rst");
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "flight_rel");
    chk("flight.starve_post", 32'(dut.starve_cnt_q), 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "flight_idle");

    // First cycle after release is arbitrated normally.
    tick(1, 0, 10'd0, 0, 10'd0, 0, 0, "rel_rst");
    tick(0, 1, 10'd8, 0, 10'd0, 1, 0, "rel_first");
    for (int i = 0; i < 2; i++) tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "rel_drain");
    tick(0, 0, 10'd0, 0, 10'd0, 0, 0, "rel_drain");
    chk("rel.valid", 32'(bus.o_drv_valid), 1);
    chk("rel.data", 32'(bus.o_drv_data), 32'h0A08);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
